// File: rtl/pc_fetch_redirect_pkg.sv
// Shared types and constants for the IF-stage program counter and its redirect buffer.
package pc_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_BRANCH,
        SRC_JUMP,
        SRC_PEND
    } redirect_src_t;

    // Fetch addresses are word aligned, so the low two bits of any target are forced to zero.
    function automatic logic [PC_W-1:0] sanitise(input logic [PC_W-1:0] t);
        return {t[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_redirect_if.sv
// Fetch-stage bus: hazard/redirect requests in, PC and status out.
interface pc_fetch_redirect_if #(
    parameter int CNT_W = 16
);
    import pc_pkg::*;

    logic             stall;
    logic             jump_valid;
    logic [PC_W-1:0]  jump_target;
    logic             branch_valid;
    logic [PC_W-1:0]  branch_target;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_plus_four;
    logic [3:0]       upper_pc_plus_four;
    logic             flush;
    logic             misalign_err;
    logic [CNT_W-1:0] redirect_count;

    modport master (
        output stall, jump_valid, jump_target, branch_valid, branch_target,
        input  pc, pc_plus_four, upper_pc_plus_four, flush, misalign_err, redirect_count
    );

    modport slave (
        input  stall, jump_valid, jump_target, branch_valid, branch_target,
        output pc, pc_plus_four, upper_pc_plus_four, flush, misalign_err, redirect_count
    );

endinterface

// File: rtl/pc_fetch_redirect_buffer.sv
// One-entry holding register for redirects that arrive while the PC is stalled.
module pc_redirect_buffer
    import pc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  redirect_src_t   req_src,
    input  logic [PC_W-1:0] req_target,
    output logic            pend_valid,
    output logic [PC_W-1:0] pend_target
);

    redirect_src_t   pend_src;
    logic [PC_W-1:0] pend_target_q;
    logic            capture;

    // A branch always replaces what is held; a jump only fills an empty slot.
    always_comb begin
        capture = 1'b0;
        if (stall) begin
            if (req_src == SRC_BRANCH) begin
                capture = 1'b1;
            end else if (req_src == SRC_JUMP && pend_src == SRC_NONE) begin
                capture = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_src      <= SRC_NONE;
            pend_target_q <= '0;
        end else if (!stall) begin
            pend_src      <= SRC_NONE;
            pend_target_q <= '0;
        end else if (capture) begin
            pend_src      <= req_src;
            pend_target_q <= req_target;
        end
    end

    assign pend_valid  = (pend_src != SRC_NONE);
    assign pend_target = pend_target_q;

endmodule

// File: rtl/pc_fetch_redirect.sv
// IF-stage program counter: selects branch/jump/pending/sequential next PC and reports flush and errors.
module pc_fetch_redirect
    import pc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int              CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_fetch_redirect_if.slave   bus
);

    redirect_src_t   sel_src;
    logic [PC_W-1:0] sel_raw;
    logic [PC_W-1:0] sel_target;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_plus_four;
    logic            apply;
    logic            flush_q;
    logic            misalign_q;
    logic [CNT_W-1:0] count_q;
    logic            pend_valid;
    logic [PC_W-1:0] pend_target;

    // EX is older than ID, so a resolved branch outranks a jump in the same cycle.
    always_comb begin
        sel_src = SRC_NONE;
        sel_raw = '0;
        if (bus.branch_valid) begin
            sel_src = SRC_BRANCH;
            sel_raw = bus.branch_target;
        end else if (bus.jump_valid) begin
            sel_src = SRC_JUMP;
            sel_raw = bus.jump_target;
        end
    end

    assign sel_target   = sanitise(sel_raw);
    assign pc_plus_four = pc_q + 32'd4;

    pc_redirect_buffer u_buffer (
        .clk         (clk),
        .reset       (reset),
        .stall       (bus.stall),
        .req_src     (sel_src),
        .req_target  (sel_target),
        .pend_valid  (pend_valid),
        .pend_target (pend_target)
    );

    always_comb begin
        pc_next = pc_q;
        apply   = 1'b0;
        if (!bus.stall) begin
            if (sel_src != SRC_NONE) begin
                pc_next = sel_target;
                apply   = 1'b1;
            end else if (pend_valid) begin
                pc_next = pend_target;
                apply   = 1'b1;
            end else begin
                pc_next = pc_plus_four;
            end
        end
    end

    // Flush is registered so it lines up with the cycle the redirected PC is visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q    <= pc_next;
            flush_q <= apply;
            if (sel_src != SRC_NONE && sel_raw[1:0] != 2'b00) begin
                misalign_q <= 1'b1;
            end
            if (apply && count_q != {CNT_W{1'b1}}) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign bus.pc                 = pc_q;
    assign bus.pc_plus_four       = pc_plus_four;
    assign bus.upper_pc_plus_four = pc_plus_four[31:28];
    assign bus.flush              = flush_q;
    assign bus.misalign_err       = misalign_q;
    assign bus.redirect_count     = count_q;

endmodule
